// File: rtl/button_conditioner_if.sv
// Signal bundle between a raw switch input and its conditioned level and strobes.
// The master drives the raw switch, and the slave returns the debounced level and the strobes.
interface button_conditioner_if;
    logic A_noisy;
    logic A;
    logic rise_pulse;
    logic fall_pulse;
    logic step_pulse;
    logic held;

    modport master (
        output A_noisy,
        input  A,
        input  rise_pulse,
        input  fall_pulse,
        input  step_pulse,
        input  held
    );

    modport slave (
        input  A_noisy,
        output A,
        output rise_pulse,
        output fall_pulse,
        output step_pulse,
        output held
    );
endinterface

// File: rtl/button_conditioner.sv
// Switch front end: a two-flop synchroniser, a stable-count debounce, and edge strobes.
// It also produces a press/hold-to-repeat step strobe. Every output is registered.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | debounced level is low, waiting for a press
// ST_PRESSED | pressed, counting toward the first auto-repeat step
// ST_REPEAT  | holding, issuing a step every REPEAT_PERIOD_CYCLES
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES      = 500000,
    parameter int REPEAT_DELAY_CYCLES  = 25000000,
    parameter int REPEAT_PERIOD_CYCLES = 5000000,
    parameter int REPEAT_EN            = 1
) (
    input  logic                 Clock50M,
    input  logic                 reset,
    button_conditioner_if.slave  btn
);

    localparam int DCNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX   = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                            REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
    localparam int RCNT_W = $clog2(RMAX + 1);

    localparam logic [DCNT_W-1:0] DCNT_ONE    = DCNT_W'(1);
    localparam logic [DCNT_W-1:0] DCNT_LAST   = DCNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RCNT_W-1:0] RCNT_ONE    = RCNT_W'(1);
    localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RCNT_W-1:0] DELAY_FULL  = RCNT_W'(REPEAT_DELAY_CYCLES);
    localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(REPEAT_PERIOD_CYCLES - 1);
    localparam logic              RPT_ON      = (REPEAT_EN != 0);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_REPEAT  = 2'd2
    } state_t;

    logic              s1_q, s2_q;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic              a_q, a_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;
    logic              step_q, step_d;
    logic              held_q, held_d;
    logic [RCNT_W-1:0] rcnt_q, rcnt_d;
    state_t            state_q, state_d;
    logic              rise_ev, fall_ev;

    // A changes only after DEBOUNCE_CYCLES consecutive disagreeing cycles at s2.
    always_comb begin
        a_d    = a_q;
        dcnt_d = '0;
        if (s2_q != a_q) begin
            if (dcnt_q == DCNT_LAST) begin
                a_d = s2_q;
            end else begin
                dcnt_d = dcnt_q + DCNT_ONE;
            end
        end
    end

    assign rise_ev = a_d & ~a_q;
    assign fall_ev = ~a_d & a_q;
    assign rise_d  = rise_ev;
    assign fall_d  = fall_ev;

    // Release takes priority over any coinciding repeat step.
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        step_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                rcnt_d = '0;
                if (rise_ev) begin
                    state_d = ST_PRESSED;
                    step_d  = 1'b1;
                end
            end
            ST_PRESSED: begin
                if (fall_ev) begin
                    state_d = ST_IDLE;
                    rcnt_d  = '0;
                end else if (RPT_ON && rcnt_q == DELAY_LAST) begin
                    state_d = ST_REPEAT;
                    step_d  = 1'b1;
                    rcnt_d  = '0;
                end else if (rcnt_q != DELAY_FULL) begin
                    rcnt_d = rcnt_q + RCNT_ONE;
                end
            end
            ST_REPEAT: begin
                if (fall_ev) begin
                    state_d = ST_IDLE;
                    rcnt_d  = '0;
                end else if (rcnt_q == PERIOD_LAST) begin
                    step_d = 1'b1;
                    rcnt_d = '0;
                end else begin
                    rcnt_d = rcnt_q + RCNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                rcnt_d  = '0;
            end
        endcase
        held_d = (state_d == ST_REPEAT);
    end

    always_ff @(posedge Clock50M or posedge reset) begin
        if (reset) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            dcnt_q  <= '0;
            a_q     <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            step_q  <= 1'b0;
            held_q  <= 1'b0;
            rcnt_q  <= '0;
            state_q <= ST_IDLE;
        end else begin
            s1_q    <= btn.A_noisy;
            s2_q    <= s1_q;
            dcnt_q  <= dcnt_d;
            a_q     <= a_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            step_q  <= step_d;
            held_q  <= held_d;
            rcnt_q  <= rcnt_d;
            state_q <= state_d;
        end
    end

    assign btn.A          = a_q;
    assign btn.rise_pulse = rise_q;
    assign btn.fall_pulse = fall_q;
    assign btn.step_pulse = step_q;
    assign btn.held       = held_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench: a table-driven clean press with release during repeat, bounce rejection,
// hold with reset mid-repeat, and a REPEAT_EN=0 instance.
module tb_button_conditioner;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests  = 0;
    int   failed = 0;

    always #10 clk = ~clk;

    button_conditioner_if bif ();
    button_conditioner_if bif2 ();

    button_conditioner #(
        .DEBOUNCE_CYCLES(4), .REPEAT_DELAY_CYCLES(10),
        .REPEAT_PERIOD_CYCLES(3), .REPEAT_EN(1)
    ) dut (
        .Clock50M(clk), .reset(rst), .btn(bif)
    );

    button_conditioner #(
        .DEBOUNCE_CYCLES(4), .REPEAT_DELAY_CYCLES(10),
        .REPEAT_PERIOD_CYCLES(3), .REPEAT_EN(0)
    ) dut2 (
        .Clock50M(clk), .reset(rst), .btn(bif2)
    );

    typedef struct {
        logic a_noisy;
        logic exp_a;
        logic exp_rise;
        logic exp_fall;
        logic exp_step;
        logic exp_held;
    } vec_t;

    vec_t vecs[31];

    task automatic chk(input string name, input int e, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s edge %0d: got %b expected %b", name, e, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int e, input logic ea, input logic er,
                           input logic ef, input logic es, input logic eh);
        chk({tag, ".A"},    e, bif.A,          ea);
        chk({tag, ".rise"}, e, bif.rise_pulse, er);
        chk({tag, ".fall"}, e, bif.fall_pulse, ef);
        chk({tag, ".step"}, e, bif.step_pulse, es);
        chk({tag, ".held"}, e, bif.held,       eh);
    endtask

    // After this returns, the next rising edge is edge 0.
    task automatic do_reset();
        rst = 1'b1;
        bif.A_noisy  = 1'b0;
        bif2.A_noisy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic bounce[20];
        int   steps2;

        // Clean press at edge 1, auto-repeat at 16 and 19, release lands A low on edge 22
        for (int k = 0; k < 31; k++) begin
            vecs[k].a_noisy  = (k >= 1 && k <= 16);
            vecs[k].exp_a    = (k >= 6 && k <= 21);
            vecs[k].exp_rise = (k == 6);
            vecs[k].exp_fall = (k == 22);
            vecs[k].exp_step = (k == 6 || k == 16 || k == 19);
            vecs[k].exp_held = (k >= 16 && k <= 21);
        end

        bif.A_noisy  = 1'b0;
        bif2.A_noisy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        do_reset();
        for (int k = 0; k < 31; k++) begin
            bif.A_noisy = vecs[k].a_noisy;
            @(posedge clk);
            #1;
            chk_all("press_release", k, vecs[k].exp_a, vecs[k].exp_rise,
                    vecs[k].exp_fall, vecs[k].exp_step, vecs[k].exp_held);
        end

        // Bounce runs of 3, 1 and 2 cycles never reach the 4-cycle threshold
        bounce = '{0,1,1,1,0,0,1,0,0,1,1,0,0,0,0,0,0,0,0,0};
        do_reset();
        for (int k = 0; k < 20; k++) begin
            bif.A_noisy = bounce[k];
            @(posedge clk);
            #1;
            chk_all("bounce", k, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Hold: steps at 6,16,19,22,25, then reset mid-repeat with the switch still high
        do_reset();
        for (int e = 0; e <= 27; e++) begin
            bif.A_noisy = (e >= 1);
            @(posedge clk);
            #1;
            chk_all("hold", e, (e >= 6), (e == 6), 1'b0,
                    (e == 6 || e == 16 || e == 19 || e == 22 || e == 25), (e >= 16));
        end
        #3 rst = 1'b1;
        #1;
        chk_all("async_reset", 28, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk_all("in_reset", 28, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int e = 0; e <= 20; e++) begin
            @(posedge clk);
            #1;
            chk_all("after_reset", e, (e >= 5), (e == 5), 1'b0,
                    (e == 5 || e == 15 || e == 18), (e >= 15));
        end

        // REPEAT_EN=0: high on edges 1..60, a single step, held never set, fall on edge 66
        do_reset();
        steps2 = 0;
        for (int e = 0; e <= 75; e++) begin
            bif2.A_noisy = (e >= 1 && e <= 60);
            @(posedge clk);
            #1;
            if (bif2.step_pulse === 1'b1) steps2++;
            chk("no_rpt.A",    e, bif2.A,          (e >= 6 && e <= 65));
            chk("no_rpt.rise", e, bif2.rise_pulse, (e == 6));
            chk("no_rpt.fall", e, bif2.fall_pulse, (e == 66));
            chk("no_rpt.step", e, bif2.step_pulse, (e == 6));
            chk("no_rpt.held", e, bif2.held,       1'b0);
        end
        tests++;
        if (steps2 != 1) begin
            failed++;
            $display("FAIL no_rpt.step_count: got %0d expected 1", steps2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
